// File: rtl/shift_pkg.sv
// Shared definitions for the FP alignment shifter.
// Mode encodings, level/stage sizing and the default stage payload.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int PL_WIDTH = 53;
    localparam int PL_TAG_W = 4;

    function automatic int levels_f(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int nstg_f(input int levels, input int reg_every);
        return (levels + reg_every - 1) / reg_every;
    endfunction

    typedef struct packed {
        logic [PL_WIDTH-1:0] data;
        logic                sticky;
        logic                lost;
        logic [PL_TAG_W-1:0] tag;
    } payload_t;

endpackage

// File: rtl/shift_level.sv
// One power-of-two shift level of the alignment shifter.
// Shifts by SHIFT when enabled and folds discarded bits into sticky/lost.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sticky,
    input  logic             lost,
    output logic [WIDTH-1:0] shifted,
    output logic             sticky_nx,
    output logic             lost_nx
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] LO_MASK =
        (SHIFT >= WIDTH) ? ONES : ~(ONES << SHIFT);
    localparam logic [WIDTH-1:0] HI_MASK =
        (SHIFT >= WIDTH) ? ONES : ~(ONES >> SHIFT);

    logic [WIDTH-1:0] rot;
    assign rot = WIDTH'({data, data} >> SHIFT);

    // Apply this level's shift and accumulate the bits it discards
    always_comb begin
        shifted   = data;
        sticky_nx = sticky;
        lost_nx   = lost;
        if (en) begin
            unique case (mode)
                SH_LSL: begin
                    shifted = data << SHIFT;
                    lost_nx = lost | (|(data & HI_MASK));
                end
                SH_LSR: begin
                    shifted   = data >> SHIFT;
                    sticky_nx = sticky | (|(data & LO_MASK));
                end
                SH_ASR: begin
                    shifted   = $signed(data) >>> SHIFT;
                    sticky_nx = sticky | (|(data & LO_MASK));
                end
                SH_ROR: begin
                    shifted = rot;
                end
            endcase
        end
    end

endmodule

// File: rtl/fp_align_shifter.sv
// Pipelined log-level barrel shifter for FP mantissa alignment.
// Registers every REG_EVERY levels with valid/ready back-pressure.
module fp_align_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH     = 53,
    parameter int AMT_W     = 11,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic             out_lost,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = levels_f(WIDTH);
    localparam int NSTG   = nstg_f(LEVELS, REG_EVERY);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic              sticky;
        logic              lost;
        logic [TAG_W-1:0]  tag;
        logic [LEVELS-1:0] amt;
        logic [1:0]        mode;
    } stage_t;

    logic [LEVELS-1:0] eff;
    stage_t            head;
    stage_t            lin   [LEVELS];
    stage_t            lout  [LEVELS];
    stage_t            sreg  [NSTG];
    stage_t            snext [NSTG];
    logic [NSTG-1:0]   sv;
    logic [NSTG-1:0]   pv;
    logic [NSTG-1:0]   free;

    // Effective amount: clamp to WIDTH, or reduce modulo WIDTH for rotate
    always_comb begin
        if (in_mode == SH_ROR)
            eff = LEVELS'(in_amt % AMT_W'(WIDTH));
        else if (in_amt >= AMT_W'(WIDTH))
            eff = LEVELS'(WIDTH);
        else
            eff = LEVELS'(in_amt);
    end

    assign head = '{data: in_data, sticky: 1'b0, lost: 1'b0,
                    tag: in_tag, amt: eff, mode: in_mode};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] q;
        logic             qs;
        logic             ql;

        if (k == 0) begin : g_head
            assign lin[k] = head;
        end else if (k % REG_EVERY == 0) begin : g_reg
            assign lin[k] = sreg[k/REG_EVERY-1];
        end else begin : g_chain
            assign lin[k] = lout[k-1];
        end

        shift_level #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k)
        ) u_lvl (
            .data     (lin[k].data),
            .en       (lin[k].amt[k]),
            .mode     (lin[k].mode),
            .sticky   (lin[k].sticky),
            .lost     (lin[k].lost),
            .shifted  (q),
            .sticky_nx(qs),
            .lost_nx  (ql)
        );

        assign lout[k] = '{data: q, sticky: qs, lost: ql,
                           tag: lin[k].tag, amt: lin[k].amt,
                           mode: lin[k].mode};
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int LAST = ((s + 1) * REG_EVERY < LEVELS) ?
                              (s + 1) * REG_EVERY - 1 : LEVELS - 1;
        assign snext[s] = lout[LAST];
    end

    // Stage load enables: a stage loads when empty or its successor takes it
    always_comb begin
        logic take;
        take = out_ready;
        free = '0;
        pv   = '0;
        for (int s = NSTG - 1; s >= 0; s--) begin
            free[s] = !sv[s] || take;
            take    = free[s];
        end
        pv[0] = in_valid;
        for (int s = 1; s < NSTG; s++)
            pv[s] = sv[s-1];
    end

    // Pipeline registers: advance when free, hold payload when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int s = 0; s < NSTG; s++)
                sreg[s] <= '0;
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                if (free[s]) begin
                    sv[s] <= pv[s];
                    if (pv[s])
                        sreg[s] <= snext[s];
                end
            end
        end
    end

    assign in_ready   = free[0];
    assign out_valid  = sv[NSTG-1];
    assign out_data   = sreg[NSTG-1].data;
    assign out_sticky = sreg[NSTG-1].sticky;
    assign out_lost   = sreg[NSTG-1].lost;
    assign out_tag    = sreg[NSTG-1].tag;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter at REG_EVERY 2, 1 and 6.
// Expected results come from a wide-arithmetic reference model.
module tb_fp_align_shifter;
    import shift_pkg::*;

    localparam int W  = 53;
    localparam int AW = 11;
    localparam int TW = 4;
    localparam int LAT [3] = '{3, 6, 1};

    typedef struct {
        logic [W-1:0]  d;
        logic          s;
        logic          l;
        logic [TW-1:0] t;
        int            acc;
        bit            exact;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_ready = 0;
    logic          iv_aux;

    logic          ov  [3];
    logic          ir  [3];
    logic [W-1:0]  od  [3];
    logic          os  [3];
    logic          ol  [3];
    logic [TW-1:0] ot  [3];

    exp_t sb [3][$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    bit   lat_exact = 1;
    bit   bp_phase = 0;
    int   bp_pops = 0;
    int   bp_first = 0;
    int   bp_last = 0;
    int   pops0 = 0;

    always #5 clk = ~clk;

    assign iv_aux = in_valid && ir[0];

    fp_align_shifter #(.WIDTH(W), .AMT_W(AW), .REG_EVERY(2), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_sticky(os[0]), .out_lost(ol[0]), .out_tag(ot[0]));

    fp_align_shifter #(.WIDTH(W), .AMT_W(AW), .REG_EVERY(1), .TAG_W(TW)) u_re1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir[1]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(1'b1), .out_data(od[1]),
        .out_sticky(os[1]), .out_lost(ol[1]), .out_tag(ot[1]));

    fp_align_shifter #(.WIDTH(W), .AMT_W(AW), .REG_EVERY(6), .TAG_W(TW)) u_re6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir[2]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(1'b1), .out_data(od[2]),
        .out_sticky(os[2]), .out_lost(ol[2]), .out_tag(ot[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] d, input int amt,
                                  input logic [1:0] m, output logic [W-1:0] r,
                                  output logic st, output logic lo);
        int                     a;
        logic [2*W-1:0]         t;
        logic signed [2*W-1:0]  ts;
        a  = (amt > W) ? W : amt;
        r  = '0;
        st = 1'b0;
        lo = 1'b0;
        case (m)
            2'b00: begin
                t  = {{W{1'b0}}, d} << a;
                r  = t[W-1:0];
                lo = |t[2*W-1:W];
            end
            2'b01: begin
                t  = {d, {W{1'b0}}} >> a;
                r  = t[2*W-1:W];
                st = |t[W-1:0];
            end
            2'b10: begin
                ts = $signed({d, {W{1'b0}}}) >>> a;
                r  = ts[2*W-1:W];
                st = |ts[W-1:0];
            end
            default: begin
                t = {d, d} >> (amt % W);
                r = t[W-1:0];
            end
        endcase
    endfunction

    task automatic push_exp(input logic [W-1:0] ed, input logic es,
                            input logic el, input logic [TW-1:0] t);
        exp_t e;
        e.d = ed; e.s = es; e.l = el; e.t = t; e.acc = cyc;
        for (int k = 0; k < 3; k++) begin
            e.exact = (k == 0) ? lat_exact : 1'b1;
            sb[k].push_back(e);
        end
    endtask

    task automatic push_model(input logic [W-1:0] d, input int a,
                              input logic [1:0] m, input logic [TW-1:0] t);
        logic [W-1:0] r;
        logic st, lo;
        model(d, a, m, r, st, lo);
        push_exp(r, st, lo, t);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_exp(input logic [W-1:0] d, input int a, input logic [1:0] m,
                            input logic [TW-1:0] t, input logic [W-1:0] ed,
                            input logic es, input logic el);
        bit got;
        got = 0;
        in_data = d; in_amt = AW'(a); in_mode = m; in_tag = t; in_valid = 1;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (ir[0]) begin
                push_exp(ed, es, el, t);
                got = 1;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got 0 expected 1");
        end
    endtask

    task automatic send(input logic [W-1:0] d, input int a,
                        input logic [1:0] m, input logic [TW-1:0] t);
        logic [W-1:0] r;
        logic st, lo;
        model(d, a, m, r, st, lo);
        send_exp(d, a, m, t, r, st, lo);
    endtask

    // Consumer ready pattern: held low, held high, or random
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (rdy_mode)
            0: out_ready = 0;
            1: out_ready = 1;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Monitor: pop and compare on handshake, check held output while stalled
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && (k != 0 || out_ready)) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("d%0d_unexpected_out", k), 1, 0);
                    end else begin
                        exp_t e;
                        int lat;
                        e = sb[k].pop_front();
                        lat = cyc - e.acc;
                        chk($sformatf("d%0d_data", k), od[k], e.d);
                        chk($sformatf("d%0d_sticky", k), os[k], e.s);
                        chk($sformatf("d%0d_lost", k), ol[k], e.l);
                        chk($sformatf("d%0d_tag", k), ot[k], e.t);
                        if (e.exact)
                            chk($sformatf("d%0d_latency", k), lat, LAT[k]);
                        else
                            chk($sformatf("d%0d_latency_min", k), lat >= LAT[k], 1);
                        if (k == 0) begin
                            pops0++;
                            if (bp_phase) begin
                                if (bp_pops == 0) bp_first = cyc;
                                bp_last = cyc;
                                bp_pops++;
                            end
                        end
                    end
                end else if (ov[k] && k == 0 && sb[0].size() > 0) begin
                    chk("stall_data", od[0], sb[0][0].d);
                    chk("stall_sticky", os[0], sb[0][0].s);
                    chk("stall_lost", ol[0], sb[0][0].l);
                    chk("stall_tag", ot[0], sb[0][0].t);
                end
                if (k != 0 && iv_aux && !ir[k])
                    chk($sformatf("d%0d_in_ready", k), ir[k], 1);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  bd [10];
        int            ba [10];
        logic [1:0]    bm [10];
        int            idx;
        int            snap;
        logic [63:0]   r64;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ov[0], 0);
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_data", od[0], 0);
        chk("rst_out_sticky", os[0], 0);
        chk("rst_out_lost", ol[0], 0);
        chk("rst_out_tag", ot[0], 0);
        rst_n = 1;
        @(posedge clk); #1;

        send_exp(53'h10000000000001, 1, 2'b01, 4'h1, 53'h08000000000000, 1, 0);
        send_exp(53'h1FFFFFFFFFFFF0, 60, 2'b10, 4'h2, 53'h1FFFFFFFFFFFFF, 1, 0);
        send_exp(53'h1FFFFFFFFFFFF0, 0, 2'b10, 4'h3, 53'h1FFFFFFFFFFFF0, 0, 0);
        send_exp(53'h18000000000000, 1, 2'b00, 4'h4, 53'h10000000000000, 0, 1);
        send_exp(53'h00000000000001, 54, 2'b11, 4'h5, 53'h10000000000000, 0, 0);
        send(53'h0ABCDEF1234567, 2047, 2'b00, 4'h6);
        send(53'h1ABCDEF1234567, 0, 2'b11, 4'h7);
        in_valid = 0;
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            r64 = {$urandom, $urandom};
            bd[i] = r64[W-1:0];
            ba[i] = $urandom_range(70);
            bm[i] = 2'($urandom_range(3));
        end
        rdy_mode = 0;
        lat_exact = 0;
        bp_phase = 1;
        @(posedge clk); #1;
        idx = 0;
        for (int c = 0; c < 80 && (idx < 10 || sb[0].size() > 0); c++) begin
            if (idx < 10) begin
                in_data = bd[idx]; in_amt = AW'(ba[idx]); in_mode = bm[idx];
                in_tag = TW'(idx); in_valid = 1;
            end else begin
                in_valid = 0;
            end
            @(negedge clk);
            if (in_valid && ir[0]) begin
                push_model(bd[idx], ba[idx], bm[idx], TW'(idx));
                idx++;
            end
            if (c == 8) begin
                chk("bp_accepted", idx, 3);
                chk("bp_in_ready_low", ir[0], 0);
                chk("bp_out_valid", ov[0], 1);
                rdy_mode = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("bp_all_accepted", idx, 10);
        chk("bp_emerged", bp_pops, 10);
        chk("bp_one_per_cycle", bp_last - bp_first, 9);
        bp_phase = 0;
        lat_exact = 1;
        repeat (8) @(posedge clk);
        #1;

        send(53'h1234, 3, 2'b01, 4'hA);
        send(53'h5678, 5, 2'b00, 4'hB);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", ov[0], 0);
        chk("midrst_out_data", od[0], 0);
        chk("midrst_out_sticky", os[0], 0);
        chk("midrst_out_lost", ol[0], 0);
        chk("midrst_out_tag", ot[0], 0);
        chk("midrst_in_ready", ir[0], 1);
        for (int k = 0; k < 3; k++) sb[k].delete();
        in_data = 53'h1F; in_amt = 1; in_mode = 2'b01; in_tag = 4'hF; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        snap = pops0;
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_stale", pops0 - snap, 0);
        chk("postrst_out_valid", ov[0], 0);
        chk("postrst_in_ready", ir[0], 1);

        rdy_mode = 2;
        lat_exact = 0;
        for (int i = 0; i < 600; i++) begin
            int a;
            r64 = {$urandom, $urandom};
            if ($urandom_range(1) == 1)
                a = $urandom_range(60);
            else
                a = $urandom_range(2047);
            send(r64[W-1:0], a, 2'($urandom_range(3)), TW'($urandom));
            if ($urandom_range(7) == 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
        end
        in_valid = 0;
        rdy_mode = 1;
        for (int n = 0; n < 200 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; n++)
            @(posedge clk);
        #1;
        chk("drain_q0", sb[0].size(), 0);
        chk("drain_q1", sb[1].size(), 0);
        chk("drain_q2", sb[2].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_align_shifter.md
# fp_align_shifter

Parametrised, pipelined log-level barrel shifter for the FP datapath: it aligns and normalises mantissas and supports four shift modes. It replaces the 53-deep unit-shift chain with ceil(log2(WIDTH+1)) power-of-two levels and places pipeline registers after every REG_EVERY levels. A valid/ready handshake with back-pressure sits on both sides. It produces a sticky bit (OR of bits shifted out on right shifts) and a lost-bit flag on left shifts, which the adder's rounding and normalisation stages need.

## Interface
- WIDTH, 53: data width in bits (mantissa including hidden bit).
- AMT_W, 11: shift-amount width (exponent-difference width).
- REG_EVERY, 2: number of shift levels between pipeline registers; range 1..LEVELS.
- TAG_W, 4: width of a sideband tag carried alongside the data unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  unsigned shift amount.
- in_mode  in  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  modes 01/10: OR of every bit shifted out; otherwise 0.
- out_lost  out  1  mode 00: any 1 shifted out of the MSB; otherwise 0.
- out_tag  out  TAG_W  tag of this beat.

## Operation
- LEVELS = clog2(WIDTH+1); for WIDTH=53, LEVELS=6. Level k shifts by 2^k when bit k of the effective amount is set.
- Effective amount by mode:
  - Modes 00/01/10: min(in_amt, WIDTH). Any in_amt ≥ WIDTH fully clears the data (mode 10 fills it with the sign), and sticky = OR of all input bits.
  - Mode 11: in_amt mod WIDTH. The modulo is computed combinationally in stage 0.
- Fill and sticky rules:
  - Mode 10 fills with the sign bit (in_data[WIDTH-1]). Sticky still ORs the discarded bits.
  - Mode 11: no bit is lost, so sticky = lost = 0.
- Sticky and lost accumulate level by level. Each level ORs in the bits it discards, and the accumulated value travels in the pipeline register together with the data.
- Amount 0 in any mode: out_data = in_data, sticky = lost = 0.

## Timing
- NSTG = ceil(LEVELS/REG_EVERY) register stages. Latency is NSTG cycles from the accepting edge to out_valid (default 3).
- A beat is accepted on the edge where in_valid && in_ready. The result is consumed on the edge where out_valid && out_ready.
- Each stage holds a valid bit. A stage loads when it is empty or its successor loads or drains that cycle.
- in_ready = !stage0_valid || stage0_advances. This ready path is combinational from out_ready through every stage; no skid buffer.
- Throughput is 1 beat/cycle while out_ready=1. With out_ready low, up to NSTG beats are buffered, then in_ready drops.
- A stalled stage holds data, sticky, lost and tag stable. out_* must not change while out_valid && !out_ready.
- Reset (asserted asynchronously at any time, including mid-flight):
  - All valid bits clear, so out_valid=0 and in-flight beats are dropped.
  - out_data, out_sticky, out_lost and out_tag reset to 0.
  - in_ready=1 after reset.
- If in_valid is asserted during reset, the beat is ignored.
- Simultaneous accept and drain at full occupancy is legal; occupancy is unchanged.

## Structure
- Package shift_pkg holds:
  - The mode encodings SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11.
  - The LEVELS/NSTG calculation.
  - The stage-payload struct {data, sticky, lost, tag}.
- Sub-module shift_level: one combinational power-of-two level with parameters WIDTH and SHIFT. It takes data, an enable, the mode, and the incoming sticky/lost, and returns the shifted data and the updated sticky/lost. The top instantiates LEVELS of these through generate, inserting a register every REG_EVERY levels.

## Test plan
- WIDTH=53, mode 01, data=0x10_0000_0000_0001, amt=1 → data=0x08_0000_0000_0000, sticky=1, 3 cycles after accept.
- Mode 10, data=0x1F_FFFF_FFFF_FFF0, amt=60 → data all ones, sticky=1. Same data with amt=0 → unchanged, sticky=0.
- Mode 00, data=0x18_0000_0000_0000, amt=1 → data=0x10_0000_0000_0000, lost=1. Mode 11, data=1, amt=54 → data=0x10_0000_0000_0000, lost=0.
- Back-pressure:
  - Stream 10 beats with out_ready held low. Exactly 3 are accepted, in_ready goes low and outputs stay stable.
  - Raise out_ready. All 10 beats emerge in order with the correct tags, 1 per cycle.
- Assert rst_n=0 with 2 beats in flight → out_valid=0 and all outputs 0 immediately. After release, no stale beat appears and in_ready=1.
- Random sweep over all modes, amounts 0..2047 and REG_EVERY∈{1,2,6}, checked against a reference model for data, sticky, lost and latency.
